dmem_cache_ctrl: RTL
====================

DMEM_CACHE_CTRL -- requirements
Module: dmem_cache_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 16, meaning the number of direct-mapped lines of four 32-bit words each.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the word-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cpu_read, input, 1 bit: CPU read request, sampled in IDLE only.
REQ-006 The block SHALL have port cpu_write, input, 1 bit: CPU write request, sampled in IDLE only.
REQ-007 The block SHALL have port cpu_addr, input, ADDR_W bits: word address; offset [1:0], index [5:2], tag [9:6].
REQ-008 The block SHALL have port cpu_wdata, input, 32 bits: write data.
REQ-009 The block SHALL have port cpu_rdata, output, 32 bits: read data, valid while cpu_done=1.
REQ-010 The block SHALL have port cpu_done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port cpu_busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have ports mem_read and mem_write, output, 1 bit each: memory strobes.
REQ-013 The block SHALL have ports mem_addr (ADDR_W) and mem_wdata (32), output: memory address and write word.
REQ-014 The block SHALL have port mem_rdata, input, 128 bits: block read; word offset 0 in [127:96], offset 3 in [31:0].
REQ-015 The block SHALL have port mem_ready, input, 1 bit: one-cycle memory completion pulse.
REQ-016 The block SHALL have ports hit_count and miss_count, output, 16 bits each: saturating statistics.

Function
REQ-017 The FSM SHALL have states IDLE, LOOKUP, FILL and WRITE.
REQ-018 In IDLE, a request SHALL be accepted at the clock edge, latching addr/wdata and going to LOOKUP.
REQ-019 When cpu_read and cpu_write are both high in IDLE, the read SHALL win and the write SHALL be dropped.
REQ-020 A LOOKUP read hit SHALL pulse cpu_done with the addressed word and return to IDLE (2-cycle latency from acceptance edge).
REQ-021 A LOOKUP read miss SHALL drive mem_addr to {tag,index,2'b00}, pulse mem_read for exactly one cycle and enter FILL.
REQ-022 In FILL on mem_ready, the block SHALL write the line data, set valid, store the tag, pulse cpu_done with the offset-selected word from mem_rdata, and go to IDLE.
REQ-023 A LOOKUP write SHALL be write-through no-write-allocate: on hit update the cached word, on miss leave lines unchanged.
REQ-024 On both write hit and write miss, LOOKUP SHALL drive the full word address and data and pulse mem_write for one cycle, then enter WRITE.
REQ-025 In WRITE on mem_ready, the block SHALL pulse cpu_done and return to IDLE.
REQ-026 mem_addr and mem_wdata SHALL be held stable from the strobe until mem_ready.
REQ-027 Strobes SHALL never be high for two consecutive cycles.
REQ-028 mem_ready received in IDLE or LOOKUP SHALL be ignored.
REQ-029 A hit SHALL require valid=1 and a tag match; each LOOKUP SHALL increment exactly one of hit_count or miss_count.
REQ-030 hit_count and miss_count SHALL saturate at 16'hFFFF.
REQ-031 cpu_rdata SHALL hold its last value when cpu_done=0.

Reset
REQ-032 While rst=0, the block SHALL force state=IDLE, all valid bits=0, counters=0, and cpu_done, mem_read, mem_write, cpu_rdata, mem_addr and mem_wdata to 0.
REQ-033 Reset mid-FILL or mid-WRITE SHALL abandon the transaction with no cpu_done and no line update.
REQ-034 Tag and data arrays SHALL need no reset.

Structure
REQ-035 A shared package dmem_cache_pkg SHALL hold the state encoding, field widths and offset/index/tag bit positions.
REQ-036 Tag, valid and data storage SHALL be one sub-module, cache_line_array (1 read port, 1 line-write port, 1 word-write port).

Verification
REQ-037 After reset with memory words 0-3 = 17,9,25,17: read addr 1 -> mem_read once with mem_addr=0, then cpu_done with rdata=9 and miss_count=1.
REQ-038 Next, read addr 2 -> cpu_done 2 cycles after acceptance, rdata=25, no strobe, and hit_count=1.
REQ-039 Write addr 3 with data 42 -> mem_write with addr 3 and data 42; then read addr 3 -> hit with rdata=42.
REQ-040 Read addr 64 (index 0, tag 1) -> miss that evicts line 0; then read addr 1 -> miss again with rdata=9.
REQ-041 Assert rst during FILL -> no cpu_done, a late mem_ready is ignored, and a following read addr 1 is a miss.
REQ-042 cpu_read and cpu_write both high on addr 2 -> read served with rdata=25 and no mem_write.

Source files
------------

// File: rtl/dmem_cache_pkg.sv
// Shared definitions for the direct-mapped data cache controller:
// FSM encoding, field widths, address bit positions and a line word selector.
package dmem_cache_pkg;

    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = WORD_W * LINE_WORDS;

    // Word address layout: offset [1:0], index [IDX_LSB+IDX_W-1:IDX_LSB], tag above
    localparam int OFF_LSB     = 0;
    localparam int OFF_W       = 2;
    localparam int IDX_LSB     = OFF_LSB + OFF_W;
    localparam int IDX_W_DEF   = 4;
    localparam int TAG_LSB_DEF = IDX_LSB + IDX_W_DEF;
    localparam int TAG_W_DEF   = 4;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;
    localparam logic [1:0] ST_WRITE  = 2'd3;

    // Lines are kept in memory-bus order: offset 0 in the top word
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        return line[LINE_W-1-WORD_W*int'(off) -: WORD_W];
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/data storage: one combinational read port, one full-line write
// port (fill) and one single-word write port (write-hit update).
module cache_line_array
    import dmem_cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_line,
    input  logic              i_lw_en,
    input  logic [IDX_W-1:0]  i_lw_idx,
    input  logic [TAG_W-1:0]  i_lw_tag,
    input  logic [LINE_W-1:0] i_lw_data,
    input  logic              i_ww_en,
    input  logic [IDX_W-1:0]  i_ww_idx,
    input  logic [OFF_W-1:0]  i_ww_off,
    input  logic [WORD_W-1:0] i_ww_data
);

    logic [NUM_LINES-1:0]             r_valid;
    logic [NUM_LINES-1:0][TAG_W-1:0]  r_tag;
    logic [NUM_LINES-1:0][LINE_W-1:0] r_data;

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

    // Valid bits are the only storage that needs a reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_valid <= '0;
        else if (i_lw_en)
            r_valid[i_lw_idx] <= 1'b1;
    end

    // Tag and data arrays; a fill takes priority over a word update
    always_ff @(posedge clk) begin
        if (i_lw_en) begin
            r_tag[i_lw_idx]  <= i_lw_tag;
            r_data[i_lw_idx] <= i_lw_data;
        end else if (i_ww_en) begin
            r_data[i_ww_idx][LINE_W-1-WORD_W*int'(i_ww_off) -: WORD_W] <= i_ww_data;
        end
    end

endmodule

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One request in flight; read misses fetch a whole 4-word line.
module dmem_cache_ctrl
    import dmem_cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_is_rd;
    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_mrd;
    logic              r_mwr;
    logic [ADDR_W-1:0] r_maddr;
    logic [31:0]       r_mwdata;
    logic [15:0]       r_hit_cnt;
    logic [15:0]       r_miss_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [OFF_W-1:0]  w_off;
    logic              w_valid;
    logic [TAG_W-1:0]  w_line_tag;
    logic [LINE_W-1:0] w_line;
    logic              w_hit;
    logic              w_lw_en;
    logic              w_ww_en;

    assign w_idx   = r_addr[TAG_LSB-1:IDX_LSB];
    assign w_tag   = r_addr[ADDR_W-1:TAG_LSB];
    assign w_off   = r_addr[IDX_LSB-1:OFF_LSB];
    assign w_hit   = w_valid && (w_line_tag == w_tag);
    // Fill lands on mem_ready; a write hit patches the cached word at lookup
    assign w_lw_en = (r_state == ST_FILL) && mem_ready;
    assign w_ww_en = (r_state == ST_LOOKUP) && !r_is_rd && w_hit;

    cache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_line  (w_line),
        .i_lw_en    (w_lw_en),
        .i_lw_idx   (w_idx),
        .i_lw_tag   (w_tag),
        .i_lw_data  (mem_rdata),
        .i_ww_en    (w_ww_en),
        .i_ww_idx   (w_idx),
        .i_ww_off   (w_off),
        .i_ww_data  (r_wdata)
    );

    // Control FSM; done and strobes default low so each is a one-cycle pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_rd    <= 1'b0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_mrd      <= 1'b0;
            r_mwr      <= 1'b0;
            r_maddr    <= '0;
            r_mwdata   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            r_mrd  <= 1'b0;
            r_mwr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_read || cpu_write) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_is_rd <= cpu_read;   // read wins when both are set
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + 16'd1;
                    end else begin
                        if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + 16'd1;
                    end
                    if (r_is_rd) begin
                        if (w_hit) begin
                            r_rdata <= line_word(w_line, w_off);
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_maddr <= {r_addr[ADDR_W-1:IDX_LSB], {OFF_W{1'b0}}};
                            r_mrd   <= 1'b1;
                            r_state <= ST_FILL;
                        end
                    end else begin
                        r_maddr  <= r_addr;
                        r_mwdata <= r_wdata;
                        r_mwr    <= 1'b1;
                        r_state  <= ST_WRITE;
                    end
                end
                ST_FILL: begin
                    if (mem_ready) begin
                        r_rdata <= line_word(mem_rdata, w_off);
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdata  = r_rdata;
    assign cpu_done   = r_done;
    assign cpu_busy   = (r_state != ST_IDLE);
    assign mem_read   = r_mrd;
    assign mem_write  = r_mwr;
    assign mem_addr   = r_maddr;
    assign mem_wdata  = r_mwdata;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule
